// File: rtl/multi_sel_collect.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// multi_sel_collect
//
// Purpose: consumer of the multi_sel result stream. A frame starts on the cycle
// in_grant is high (x1) and continues for three more cycles (x3, x7, x8). The
// four results are packed into one 44-bit word {x8, x7, x3, x1} and queued in a
// DEPTH-entry FIFO that drains through a valid/ready handshake. A frame that
// finds the FIFO full (and no pop in the same cycle) is dropped and counted.
//
// Optional feature macro: MULTI_SEL_CHECK_EN
//   When defined, each frame is checked for consistency (x1 < 256, x3 = 3*x1,
//   x7 = 7*x1, x8 = x1 << 3, 11-bit arithmetic) and carries an error bit that
//   shows on frm_err with that frame. When undefined, frm_err is constant 0.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous reset, active low
//   in_grant   in   1   frame marker, high while in_data carries x1
//   in_data    in  11   multi_sel result stream
//   frm_valid  out  1   FIFO holds at least one frame
//   frm_ready  in   1   consumer takes the head frame
//   frm_data   out 44   head frame {x8, x7, x3, x1}
//   frm_err    out  1   head frame failed the consistency check
//   drop_cnt   out  8   frames dropped on FIFO full, saturating at 255
//   resync     out  1   sticky: a grant arrived in the middle of a frame
// -----------------------------------------------------------------------------
module multi_sel_collect #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_grant,
    input  logic [10:0] in_data,
    output logic        frm_valid,
    input  logic        frm_ready,
    output logic [43:0] frm_data,
    output logic        frm_err,
    output logic [7:0]  drop_cnt,
    output logic        resync
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    typedef enum logic [1:0] {IDLE, S1, S2, S3} state_t;

    state_t      state;
    state_t      state_next;
    logic [10:0] x1;
    logic [10:0] x3;
    logic [10:0] x7;
    logic [43:0] frame;
    logic        push;
    logic        push_ok;
    logic        pop;
    logic        full;
    logic        empty;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [43:0] mem [DEPTH];

    // -------------------------------------------------------------------------
    // Capture FSM
    // -------------------------------------------------------------------------
    // NOTE: next_state gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_next = state;
        if (in_grant) begin
            // A grant always starts a new frame, even mid-frame (realignment).
            state_next = S1;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                S1:      state_next = S2;
                S2:      state_next = S3;
                S3:      state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            resync <= 1'b0;
            x1     <= '0;
            x3     <= '0;
            x7     <= '0;
        end else begin
            state <= state_next;
            if (in_grant && state != IDLE) begin
                resync <= 1'b1;
            end
            if (in_grant) begin
                x1 <= in_data;
            end else if (state == S1) begin
                x3 <= in_data;
            end else if (state == S2) begin
                x7 <= in_data;
            end
        end
    end

    // x8 is never registered: it is on in_data during S3 and goes straight
    // into the FIFO. A grant in S3 means in_data is a new x1, not x8.
    assign push  = (state == S3) && !in_grant;
    assign frame = {in_data, x7, x3, x1};

    // -------------------------------------------------------------------------
    // FIFO: extra pointer MSB distinguishes full from empty.
    // -------------------------------------------------------------------------
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign frm_valid = !empty;
    assign pop       = frm_valid && frm_ready;
    // When full, a same-cycle pop frees the head slot, which is exactly the
    // slot the write pointer addresses.
    assign push_ok   = push && (!full || pop);
    assign frm_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= '0;
            // NOTE: the storage is reset on purpose so frm_data reads 0 out of
            // reset; a plain RAM macro could not be used for this array.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= frame;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !push_ok && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

`ifdef MULTI_SEL_CHECK_EN
    // -------------------------------------------------------------------------
    // Consistency check, evaluated on the push cycle (x8 is still on in_data).
    // -------------------------------------------------------------------------
    logic [10:0] x1_times3;
    logic [10:0] x1_times7;
    logic [10:0] x1_times8;
    logic        frame_err;
    logic        err_mem [DEPTH];

    assign x1_times3 = x1 * 11'd3;
    assign x1_times7 = x1 * 11'd7;
    assign x1_times8 = x1 << 3;
    assign frame_err = (x1[10:8] != 3'd0) || (x3 != x1_times3) ||
                       (x7 != x1_times7) || (in_data != x1_times8);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                err_mem[i] <= 1'b0;
            end
        end else if (push_ok) begin
            err_mem[wr_ptr[AW-1:0]] <= frame_err;
        end
    end

    assign frm_err = err_mem[rd_ptr[AW-1:0]];
`else
    assign frm_err = 1'b0;
`endif

endmodule

// File: tb/tb_multi_sel_collect.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_multi_sel_collect
//
// Directed stimulus for multi_sel_collect. Inputs change 1 ns after the rising
// edge; the monitor samples on the falling edge. Each frame the bench expects
// to be accepted is queued at issue time; the monitor pops and compares every
// frame the DUT hands over (frm_valid && frm_ready).
// -----------------------------------------------------------------------------
module tb_multi_sel_collect;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_grant;
    logic [10:0] in_data;
    logic        frm_valid;
    logic        frm_ready;
    logic [43:0] frm_data;
    logic        frm_err;
    logic [7:0]  drop_cnt;
    logic        resync;

    always #5 clk = ~clk;

    multi_sel_collect #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_grant  (in_grant),
        .in_data   (in_data),
        .frm_valid (frm_valid),
        .frm_ready (frm_ready),
        .frm_data  (frm_data),
        .frm_err   (frm_err),
        .drop_cnt  (drop_cnt),
        .resync    (resync)
    );

    typedef struct packed {
        logic [43:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected error bit: only meaningful when the check feature is built.
    function automatic logic model_err(input logic [10:0] a, input logic [10:0] b,
                                       input logic [10:0] c, input logic [10:0] e);
        logic [10:0] a3;
        logic [10:0] a7;
        logic [10:0] a8;
        logic        bad;
        logic        en;
        a3  = a * 11'd3;
        a7  = a * 11'd7;
        a8  = {a[7:0], 3'b000};
        bad = (a[10:8] != 3'd0) || (b != a3) || (c != a7) || (e != a8);
`ifdef MULTI_SEL_CHECK_EN
        en  = 1'b1;
`else
        en  = 1'b0;
`endif
        return bad && en;
    endfunction

    task automatic drive(input logic g, input logic [10:0] d);
        @(posedge clk);
        #1;
        in_grant = g;
        in_data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 11'd0);
    endtask

    // Returns with x8 on the bus; the push happens at the next rising edge.
    task automatic send_frame(input logic [10:0] a, input logic [10:0] b,
                              input logic [10:0] c, input logic [10:0] e,
                              input bit kept);
        exp_t x;
        drive(1'b1, a);
        drive(1'b0, b);
        drive(1'b0, c);
        drive(1'b0, e);
        if (kept) begin
            x.data = {e, c, b, a};
            x.err  = model_err(a, b, c, e);
            exp_q.push_back(x);
        end
    endtask

    task automatic send_d(input int d, input bit kept);
        logic [10:0] v;
        v = 11'(d);
        send_frame(v, v * 11'd3, v * 11'd7, {v[7:0], 3'b000}, kept);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    // -------------------------------------------------------------------------
    // Monitor / scoreboard
    // -------------------------------------------------------------------------
    logic [43:0] mon_prev_data;
    logic        mon_hold = 1'b0;
    exp_t        mon_e;

    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                mon_hold = 1'b0;
            end else begin
                if (mon_hold) begin
                    check("hold_data", 64'(frm_data), 64'(mon_prev_data));
                end
                if (frm_valid && frm_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL pop_unexpected: got frame 0x%0h, wanted none (t=%0t)",
                                 frm_data, $time);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("pop_data", 64'(frm_data), 64'(mon_e.data));
                        check("pop_err", 64'(frm_err), 64'(mon_e.err));
                    end
                end
                mon_hold      = frm_valid && !frm_ready;
                mon_prev_data = frm_data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        rst       = 1'b1;
        in_grant  = 1'b0;
        in_data   = 11'd0;
        frm_ready = 1'b0;
        #2 rst = 1'b0;
        #10;
        check("rst_valid",  64'(frm_valid), 64'd0);
        check("rst_data",   64'(frm_data),  64'd0);
        check("rst_err",    64'(frm_err),   64'd0);
        check("rst_drop",   64'(drop_cnt),  64'd0);
        check("rst_resync", 64'(resync),    64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Single frame d=5, latency and one-cycle valid pulse.
        frm_ready = 1'b1;
        send_d(5, 1'b1);
        check("lat_before", 64'(frm_valid), 64'd0);
        idle(1);
        check("lat_rise", 64'(frm_valid), 64'd1);
        check("lat_data", 64'(frm_data), {20'd0, 11'd40, 11'd35, 11'd15, 11'd5});
        idle(1);
        check("lat_fall", 64'(frm_valid), 64'd0);

        // Maximum operand.
        send_d(255, 1'b1);
        idle(1);
        check("max_data", 64'(frm_data), {20'd0, 11'd2040, 11'd1785, 11'd765, 11'd255});
        idle(2);
        check("max_fall", 64'(frm_valid), 64'd0);

        // Back-pressure: six back-to-back frames into a four-deep FIFO.
        frm_ready = 1'b0;
        for (int d = 1; d <= 6; d++) begin
            send_d(d, d <= 4);
        end
        idle(1);
        check("bp_drop",  64'(drop_cnt), 64'd2);
        check("bp_valid", 64'(frm_valid), 64'd1);
        check("bp_head",  64'(frm_data), {20'd0, 11'd8, 11'd7, 11'd3, 11'd1});
        idle(3);
        frm_ready = 1'b1;
        wait_drain(20);
        #1;
        check("bp_fall", 64'(frm_valid), 64'd0);
        check("b2b_resync", 64'(resync), 64'd0);

        // Full FIFO with a pop in the same cycle as a push.
        frm_ready = 1'b0;
        for (int d = 10; d <= 13; d++) begin
            send_d(d, 1'b1);
        end
        drive(1'b1, 11'd14);
        drive(1'b0, 11'd42);
        drive(1'b0, 11'd98);
        @(posedge clk);
        #1;
        in_grant  = 1'b0;
        in_data   = 11'd112;
        frm_ready = 1'b1;
        exp_q.push_back('{data: {11'd112, 11'd98, 11'd42, 11'd14}, err: 1'b0});
        @(posedge clk);
        #1;
        in_data   = 11'd0;
        frm_ready = 1'b0;
        check("fp_drop", 64'(drop_cnt), 64'd2);
        check("fp_head", 64'(frm_data), {20'd0, 11'd88, 11'd77, 11'd33, 11'd11});
        send_d(15, 1'b0);
        idle(1);
        check("fp_still_full", 64'(drop_cnt), 64'd3);
        frm_ready = 1'b1;
        wait_drain(20);
        #1;
        check("fp_fall", 64'(frm_valid), 64'd0);

        // Grant during S2 restarts the frame.
        drive(1'b1, 11'd7);
        drive(1'b0, 11'd21);
        send_d(9, 1'b1);
        idle(1);
        check("rs_resync", 64'(resync), 64'd1);
        check("rs_data", 64'(frm_data), {20'd0, 11'd72, 11'd63, 11'd27, 11'd9});
        idle(2);

        // Inconsistent frame: error bit only with the check feature.
        send_frame(11'd5, 11'd16, 11'd35, 11'd40, 1'b1);
        idle(1);
        check("chk_err", 64'(frm_err), 64'(model_err(11'd5, 11'd16, 11'd35, 11'd40)));
        idle(2);

        // Reset in S2 with a frame waiting in the FIFO.
        frm_ready = 1'b0;
        send_d(20, 1'b1);
        idle(1);
        drive(1'b1, 11'd3);
        drive(1'b0, 11'd9);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_grant = 1'b0;
        in_data  = 11'd21;
        exp_q.delete();
        #1;
        check("mr_valid",  64'(frm_valid), 64'd0);
        check("mr_data",   64'(frm_data),  64'd0);
        check("mr_err",    64'(frm_err),   64'd0);
        check("mr_drop",   64'(drop_cnt),  64'd0);
        check("mr_resync", 64'(resync),    64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        frm_ready = 1'b1;
        idle(6);
        check("mr_no_push", 64'(frm_valid), 64'd0);
        send_d(6, 1'b1);
        idle(3);

        check("final_queue", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
